// File: rtl/gpu_pkg.sv
// Shared GPU type definitions: read-modify-write operation codes and
// the sequencer states used by the register bank's self-test engine.
package gpu_pkg;

    typedef enum logic [1:0] {
        RMW_INC  = 2'd0,
        RMW_ADD  = 2'd1,
        RMW_XOR  = 2'd2,
        RMW_LOAD = 2'd3
    } rmw_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } rmw_state_t;

endpackage

// File: rtl/reg_bank_2r1w.sv
// Flop-based register bank with two registered read ports and one write
// port; register 0 is hard-wired to zero.
module reg_bank_2r1w #(
    parameter int WORD_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int ADDRESS_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     read_a_en,
    input  logic [ADDRESS_WIDTH-1:0] read_a_address,
    output logic [WORD_WIDTH-1:0]    read_a_data,
    input  logic                     read_b_en,
    input  logic [ADDRESS_WIDTH-1:0] read_b_address,
    output logic [WORD_WIDTH-1:0]    read_b_data,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [WORD_WIDTH-1:0]    write_data
);

    localparam logic [ADDRESS_WIDTH:0] ADDRESS_LIMIT = (ADDRESS_WIDTH+1)'(REG_COUNT);

    logic [WORD_WIDTH-1:0] regs [REG_COUNT];

    // Addresses past REG_COUNT (non power-of-two banks) read as zero.
    function automatic logic [WORD_WIDTH-1:0] fetch(input logic [ADDRESS_WIDTH-1:0] address);
        if ({1'b0, address} < ADDRESS_LIMIT) begin
            return regs[address];
        end
        return '0;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && (write_address != '0) &&
                     ({1'b0, write_address} < ADDRESS_LIMIT)) begin
            regs[write_address] <= write_data;
        end
    end

    // Reads sample storage before this edge's write lands, so a same-address
    // read and write return the old value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_a_data <= '0;
            read_b_data <= '0;
        end else begin
            if (read_a_en) begin
                read_a_data <= fetch(read_a_address);
            end
            if (read_b_en) begin
                read_b_data <= fetch(read_b_address);
            end
        end
    end

endmodule

// File: rtl/reg_rmw_engine.sv
// Register bank plus a host-started read-modify-write sequencer that walks
// an address range (with wrap) applying one operation per register.
module reg_rmw_engine
    import gpu_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    localparam int ADDRESS_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] ext_address,
    input  logic                     ext_read,
    output logic [WORD_WIDTH-1:0]    ext_read_data,
    input  logic                     ext_write,
    input  logic [WORD_WIDTH-1:0]    ext_write_data,
    output logic                     ext_write_dropped,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] first_address,
    input  logic [ADDRESS_WIDTH-1:0] last_address,
    input  logic [1:0]               mode,
    input  logic [WORD_WIDTH-1:0]    operand,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH:0]   op_count
);

    localparam logic [ADDRESS_WIDTH-1:0] TOP_ADDRESS = ADDRESS_WIDTH'(REG_COUNT - 1);

    rmw_state_t                 state;
    rmw_state_t                 state_next;
    logic [ADDRESS_WIDTH-1:0]   current_address;
    logic [ADDRESS_WIDTH-1:0]   last_address_q;
    rmw_mode_t                  mode_q;
    logic [WORD_WIDTH-1:0]      operand_q;
    logic [WORD_WIDTH-1:0]      result_q;
    logic [WORD_WIDTH-1:0]      engine_read_data;
    logic                       engine_read;
    logic                       engine_write;
    logic                       last_step;
    logic                       bank_write_en;
    logic [ADDRESS_WIDTH-1:0]   bank_write_address;
    logic [WORD_WIDTH-1:0]      bank_write_data;

    assign busy      = (state != IDLE);
    assign last_step = (current_address == last_address_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        engine_read  = 1'b0;
        engine_write = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                engine_read = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                state_next = WRITE;
            end
            WRITE: begin
                engine_write = 1'b1;
                state_next   = last_step ? IDLE : READ;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pass parameters are frozen at start so host changes mid-pass are inert.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            current_address <= '0;
            last_address_q  <= '0;
            mode_q          <= RMW_INC;
            operand_q       <= '0;
            result_q        <= '0;
            op_count        <= '0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        current_address <= first_address;
                        last_address_q  <= last_address;
                        mode_q          <= rmw_mode_t'(mode);
                        operand_q       <= operand;
                        op_count        <= '0;
                    end
                end
                WAIT: begin
                    case (mode_q)
                        RMW_INC:  result_q <= engine_read_data + WORD_WIDTH'(1);
                        RMW_ADD:  result_q <= engine_read_data + operand_q;
                        RMW_XOR:  result_q <= engine_read_data ^ operand_q;
                        RMW_LOAD: result_q <= operand_q;
                        default:  result_q <= operand_q;
                    endcase
                end
                WRITE: begin
                    op_count <= op_count + (ADDRESS_WIDTH+1)'(1);
                    if (last_step) begin
                        done <= 1'b1;
                    end else if (current_address == TOP_ADDRESS) begin
                        current_address <= '0;
                    end else begin
                        current_address <= current_address + ADDRESS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_write_dropped <= 1'b0;
        end else begin
            ext_write_dropped <= ext_write && busy;
        end
    end

    // The engine owns the single write port for the whole pass.
    always_comb begin
        bank_write_en      = 1'b0;
        bank_write_address = ext_address;
        bank_write_data    = ext_write_data;
        if (busy) begin
            bank_write_en      = engine_write;
            bank_write_address = current_address;
            bank_write_data    = result_q;
        end else begin
            bank_write_en = ext_write;
        end
    end

    reg_bank_2r1w #(
        .WORD_WIDTH (WORD_WIDTH),
        .REG_COUNT  (REG_COUNT)
    ) u_bank (
        .clock          (clock),
        .reset_n        (reset_n),
        .read_a_en      (ext_read),
        .read_a_address (ext_address),
        .read_a_data    (ext_read_data),
        .read_b_en      (engine_read),
        .read_b_address (current_address),
        .read_b_data    (engine_read_data),
        .write_en       (bank_write_en),
        .write_address  (bank_write_address),
        .write_data     (bank_write_data)
    );

endmodule

// File: tb/tb_reg_rmw_engine.sv
// Self-checking bench for reg_rmw_engine: directed and randomized passes
// compared against a whole-pass behavioural model of the register file.
module tb_reg_rmw_engine;

    localparam int WW = 32;
    localparam int RC = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AW-1:0] ext_address;
    logic          ext_read;
    logic [WW-1:0] ext_read_data;
    logic          ext_write;
    logic [WW-1:0] ext_write_data;
    logic          ext_write_dropped;
    logic          start;
    logic [AW-1:0] first_address;
    logic [AW-1:0] last_address;
    logic [1:0]    mode;
    logic [WW-1:0] operand;
    logic          busy;
    logic          done;
    logic [AW:0]   op_count;

    int checks = 0;
    int errors = 0;
    logic [WW-1:0] model [RC];

    always #5 clock = ~clock;

    reg_rmw_engine #(.WORD_WIDTH(WW), .REG_COUNT(RC)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ext_address       (ext_address),
        .ext_read          (ext_read),
        .ext_read_data     (ext_read_data),
        .ext_write         (ext_write),
        .ext_write_data    (ext_write_data),
        .ext_write_dropped (ext_write_dropped),
        .start             (start),
        .first_address     (first_address),
        .last_address      (last_address),
        .mode              (mode),
        .operand           (operand),
        .busy              (busy),
        .done              (done),
        .op_count          (op_count)
    );

    // Whole-pass effect: list the visited addresses and apply the operation.
    function automatic int model_pass(input int f, input int l, input int m, input logic [WW-1:0] op);
        int n;
        int a;
        n = (l >= f) ? (l - f + 1) : (RC - f + l + 1);
        for (int k = 0; k < n; k++) begin
            a = (f + k) % RC;
            if (a != 0) begin
                case (m)
                    0:       model[a] = model[a] + 1;
                    1:       model[a] = model[a] + op;
                    2:       model[a] = model[a] ^ op;
                    default: model[a] = op;
                endcase
            end
        end
        return n;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < RC; i++) model[i] = '0;
        @(negedge clock);
    endtask

    task automatic write_reg(input int a, input logic [WW-1:0] d);
        ext_address    = AW'(a);
        ext_write_data = d;
        ext_write      = 1'b1;
        @(negedge clock);
        ext_write = 1'b0;
        if (a != 0) model[a] = d;
    endtask

    task automatic read_reg(input int a, output logic [WW-1:0] d);
        ext_address = AW'(a);
        ext_read    = 1'b1;
        @(negedge clock);
        d        = ext_read_data;
        ext_read = 1'b0;
    endtask

    // Runs one pass and measures it; callers compare the measurements.
    task automatic run_pass(input int f, input int l, input int m, input logic [WW-1:0] op,
                            output int cycles, output int dones, output int count);
        first_address = AW'(f);
        last_address  = AW'(l);
        mode          = 2'(m);
        operand       = op;
        start         = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        mode    = 2'($urandom);
        operand = $urandom;
        cycles  = 0;
        dones   = 0;
        while (busy && cycles < 400) begin
            cycles++;
            if (done) dones++;
            @(negedge clock);
        end
        if (done) dones++;
        @(negedge clock);
        if (done) dones++;
        count = int'(op_count);
    endtask

    task automatic test_reset();
        logic [WW-1:0] v;
        apply_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        checks++; if (op_count !== '0) begin errors++; $display("[TB] FAIL reset_op_count got %0d expected 0", op_count); end
        checks++; if (ext_read_data !== '0) begin errors++; $display("[TB] FAIL reset_read_data got %h expected 0", ext_read_data); end
        checks++; if (ext_write_dropped !== 1'b0) begin errors++; $display("[TB] FAIL reset_dropped got %b expected 0", ext_write_dropped); end
        for (int i = 0; i < RC; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL reset_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_increment();
        int cycles, dones, count, n;
        logic [WW-1:0] v;
        write_reg(3, 32'd5);
        write_reg(0, 32'hDEAD_BEEF);
        read_reg(0, v);
        checks++; if (v !== '0) begin errors++; $display("[TB] FAIL inc_reg0_write got %h expected 0", v); end
        n = model_pass(1, 3, 0, '0);
        run_pass(1, 3, 0, '0, cycles, dones, count);
        checks++; if (cycles != 3 * n) begin errors++; $display("[TB] FAIL inc_busy_cycles got %0d expected %0d", cycles, 3 * n); end
        checks++; if (dones != 1) begin errors++; $display("[TB] FAIL inc_done_pulses got %0d expected 1", dones); end
        checks++; if (count != n) begin errors++; $display("[TB] FAIL inc_op_count got %0d expected %0d", count, n); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL inc_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_carry_single();
        int cycles, dones, count, n;
        logic [WW-1:0] v;
        write_reg(31, 32'hFFFF_FFFF);
        n = model_pass(31, 31, 0, '0);
        run_pass(31, 31, 0, '0, cycles, dones, count);
        checks++; if (cycles != 3 * n) begin errors++; $display("[TB] FAIL carry_busy_cycles got %0d expected %0d", cycles, 3 * n); end
        checks++; if (count != 1) begin errors++; $display("[TB] FAIL carry_op_count got %0d expected 1", count); end
        read_reg(31, v);
        checks++; if (v !== model[31]) begin errors++; $display("[TB] FAIL carry_reg31 got %h expected %h", v, model[31]); end
    endtask

    task automatic test_wrap_xor();
        int cycles, dones, count, n;
        logic [WW-1:0] v;
        write_reg(30, 32'hF0);
        write_reg(31, 32'hF0);
        write_reg(1, 32'hF0);
        n = model_pass(30, 1, 2, 32'hFF);
        run_pass(30, 1, 2, 32'hFF, cycles, dones, count);
        checks++; if (count != 4) begin errors++; $display("[TB] FAIL wrap_op_count got %0d expected 4", count); end
        checks++; if (cycles != 3 * n) begin errors++; $display("[TB] FAIL wrap_busy_cycles got %0d expected %0d", cycles, 3 * n); end
        for (int i = 0; i < RC; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL wrap_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    // Read reg 5 every cycle while it is modified; refused write mid-pass.
    task automatic test_drop_concurrent();
        int c, drops, n;
        logic [WW-1:0] op, old_value, new_value, v;
        for (int i = 5; i <= 8; i++) write_reg(i, $urandom);
        op        = $urandom;
        old_value = model[5];
        n         = model_pass(5, 8, 1, op);
        new_value = model[5];
        first_address = AW'(5);
        last_address  = AW'(8);
        mode          = 2'd1;
        operand       = op;
        ext_address   = AW'(5);
        ext_read      = 1'b1;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c     = 0;
        drops = 0;
        while (c < 100) begin
            checks++;
            if (ext_read_data !== ((c >= 4) ? new_value : old_value)) begin
                errors++; $display("[TB] FAIL concurrent_read_c%0d got %h expected %h", c, ext_read_data, (c >= 4) ? new_value : old_value);
            end
            if (ext_write_dropped) drops++;
            if (c == 2) begin
                checks++; if (ext_write_dropped !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse_timing got %b expected 1", ext_write_dropped); end
            end
            ext_write      = (c == 1);
            ext_write_data = $urandom;
            if (!busy) break;
            @(negedge clock);
            c++;
        end
        ext_write = 1'b0;
        ext_read  = 1'b0;
        checks++; if (c != 3 * n) begin errors++; $display("[TB] FAIL drop_busy_cycles got %0d expected %0d", c, 3 * n); end
        checks++; if (drops != 1) begin errors++; $display("[TB] FAIL drop_pulse_count got %0d expected 1", drops); end
        @(negedge clock);
        for (int i = 5; i <= 8; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL drop_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_reset_mid_pass();
        int dones;
        logic [WW-1:0] v;
        first_address = AW'(1);
        last_address  = AW'(31);
        mode          = 2'd3;
        operand       = 32'hA5;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) dones++;
            @(negedge clock);
        end
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b expected 0", done); end
        checks++; if (op_count !== '0) begin errors++; $display("[TB] FAIL midreset_op_count got %0d expected 0", op_count); end
        reset_n = 1'b1;
        for (int i = 0; i < RC; i++) model[i] = '0;
        for (int c = 0; c < 5; c++) begin
            if (done) dones++;
            @(negedge clock);
        end
        checks++; if (dones != 0) begin errors++; $display("[TB] FAIL midreset_done_pulses got %0d expected 0", dones); end
        for (int i = 0; i < RC; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL midreset_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int c, cycles, na, nb;
        logic [WW-1:0] opa, opb, v;
        opa = $urandom;
        opb = $urandom;
        na  = model_pass(2, 4, 1, opa);
        nb  = model_pass(10, 12, 2, opb);
        first_address = AW'(2);
        last_address  = AW'(4);
        mode          = 2'd1;
        operand       = opa;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 0;
        while (!done && c < 100) begin
            c++;
            @(negedge clock);
        end
        checks++; if (c != 3 * na) begin errors++; $display("[TB] FAIL b2b_first_cycles got %0d expected %0d", c, 3 * na); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_busy got %b expected 0", busy); end
        checks++; if (op_count != na) begin errors++; $display("[TB] FAIL b2b_first_count got %0d expected %0d", op_count, na); end
        first_address = AW'(10);
        last_address  = AW'(12);
        mode          = 2'd2;
        operand       = opb;
        start         = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_busy got %b expected 1", busy); end
        checks++; if (op_count !== '0) begin errors++; $display("[TB] FAIL b2b_count_restart got %0d expected 0", op_count); end
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            @(negedge clock);
        end
        checks++; if (cycles != 3 * nb) begin errors++; $display("[TB] FAIL b2b_second_cycles got %0d expected %0d", cycles, 3 * nb); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_done got %b expected 1", done); end
        checks++; if (op_count != nb) begin errors++; $display("[TB] FAIL b2b_second_count got %0d expected %0d", op_count, nb); end
        @(negedge clock);
        for (int i = 2; i <= 12; i++) begin
            read_reg(i, v);
            checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL b2b_reg%0d got %h expected %h", i, v, model[i]); end
        end
    endtask

    task automatic test_random_passes();
        int f, l, m, n, cycles, dones, count;
        logic [WW-1:0] op, v;
        for (int i = 1; i < RC; i++) write_reg(i, $urandom);
        for (int p = 0; p < 6; p++) begin
            f  = $urandom_range(RC - 1, 0);
            l  = $urandom_range(RC - 1, 0);
            m  = $urandom_range(3, 0);
            op = $urandom;
            n  = model_pass(f, l, m, op);
            run_pass(f, l, m, op, cycles, dones, count);
            checks++; if (cycles != 3 * n) begin errors++; $display("[TB] FAIL rand%0d_busy_cycles got %0d expected %0d", p, cycles, 3 * n); end
            checks++; if (dones != 1) begin errors++; $display("[TB] FAIL rand%0d_done_pulses got %0d expected 1", p, dones); end
            checks++; if (count != n) begin errors++; $display("[TB] FAIL rand%0d_op_count got %0d expected %0d", p, count, n); end
            for (int i = 0; i < RC; i++) begin
                read_reg(i, v);
                checks++; if (v !== model[i]) begin errors++; $display("[TB] FAIL rand%0d_reg%0d got %h expected %h", p, i, v, model[i]); end
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        ext_address    = '0;
        ext_read       = 1'b0;
        ext_write      = 1'b0;
        ext_write_data = '0;
        start          = 1'b0;
        first_address  = '0;
        last_address   = '0;
        mode           = 2'd0;
        operand        = '0;
        @(negedge clock);
        test_reset();
        test_increment();
        test_carry_single();
        test_wrap_xor();
        test_drop_concurrent();
        test_reset_mid_pass();
        test_back_to_back();
        test_random_passes();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_rmw_engine.md
# reg_rmw_engine

Parametrised register bank with a built-in read-modify-write sequencer. It generalises the fixed "read x1, wait, write x1+1" test loop into a host-started engine. The engine walks an address range and applies a selectable operation to each register. A dedicated external read port stays usable throughout. It sits beside the instruction and data block RAMs in the GPU top level, as the register bank plus its self-test/initialisation engine.

## Interface
Parameters:
- WORD_WIDTH, 32, register width in bits.
- REG_COUNT, 32, number of registers, 2..64.
- ADDRESS_WIDTH, $clog2(REG_COUNT), register address width (derived; do not override).

Ports:
- clock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- ext_address  in  ADDRESS_WIDTH  external read/write address.
- ext_read  in  1  external read request.
- ext_read_data  out  WORD_WIDTH  registered read data; reset 0.
- ext_write  in  1  external write strobe.
- ext_write_data  in  WORD_WIDTH  external write data.
- ext_write_dropped  out  1  one-cycle pulse, external write refused; reset 0.
- start  in  1  begin an RMW pass (sampled in IDLE only).
- first_address  in  ADDRESS_WIDTH  first register of the pass.
- last_address  in  ADDRESS_WIDTH  last register of the pass.
- mode  in  2  0 increment, 1 add operand, 2 xor operand, 3 load operand.
- operand  in  WORD_WIDTH  operand for modes 1–3.
- busy  out  1  pass in progress; reset 0.
- done  out  1  one-cycle pulse at pass completion; reset 0.
- op_count  out  ADDRESS_WIDTH+1  registers written in current/last pass; reset 0.

## Operation
- Storage is REG_COUNT words of flops, cleared to 0 by reset_n. Register 0 reads as 0, and all writes to it (external or engine) are discarded.
- There are two read ports: external and engine. There is one write port, owned by the engine while busy.
- External read: when ext_read is high, ext_read_data is loaded with reg[ext_address] on the next edge. When ext_read is low, ext_read_data holds its value.
- External write: when busy=0, reg[ext_address] is updated on the edge. When busy=1, the write is discarded and ext_write_dropped pulses in the following cycle.
- FSM states are IDLE, READ, WAIT, WRITE.
  - IDLE: if start is high, latch first_address, last_address, mode and operand; clear op_count; go to READ.
  - READ: engine read of the current address; go to WAIT.
  - WAIT: engine read data is valid. Compute the result into a holding register; go to WRITE.
  - WRITE: write the result and increment op_count.
    - If current == last_address, go to IDLE and pulse done.
    - Otherwise set current = (current+1) mod REG_COUNT and go to READ.
- Arithmetic is modulo 2^WORD_WIDTH. Carries are dropped, so 0xFFFFFFFF+1 = 0.
- Range rules:
  - first > last wraps through REG_COUNT-1 to 0 and continues up to last.
  - first == last processes exactly one register.
  - Address 0 inside a range is visited (it costs cycles and counts in op_count), but its write is discarded.
- start while busy is ignored. Mode and operand changes while busy have no effect.

## Timing
- Read latency is 1 cycle, on both ports. A read and a write to the same address on the same edge return the old value.
- start is sampled at edge k; busy is high from edge k.
- A pass over N registers keeps busy high for exactly 3N cycles.
- busy falls and done rises on the same edge, the one after the last WRITE cycle. done stays high for exactly one cycle.
- op_count is valid and stable while IDLE after done.
- Reset mid-pass returns the block to IDLE immediately: busy, done and op_count go to 0, and storage is cleared. No partial write may survive reset.
- Back-to-back passes: start may be high in the same cycle done is high, and the new pass begins on that edge.

## Structure
- Shared package gpu_pkg holds:
  - the rmw_mode_t enum (RMW_INC, RMW_ADD, RMW_XOR, RMW_LOAD);
  - the rmw_state_t enum (IDLE, READ, WAIT, WRITE).
- One sub-module, reg_bank_2r1w, holds the storage, the x0 hard-zero rule, two registered read ports and one write port. It is parametrised by WORD_WIDTH and REG_COUNT.
- The sequencer, operation mux and drop logic live in reg_rmw_engine.

## Test plan
- After reset, write 5 to reg 3, then start with first=1, last=3, mode=0. Required: busy for 9 cycles, done once; reg1=1, reg2=1, reg3=6, reg0=0; op_count=3.
- Preload reg 31 with 0xFFFFFFFF, then start with first=last=31, mode=0. Required: reg31=0, busy for 3 cycles.
- Preload regs 30, 31, 1 with 0xF0, then start with first=30, last=1, mode=2, operand=0xFF (wrap). Required: regs 30, 31, 1 = 0x0F; reg0 unchanged at 0; op_count=4.
- Set ext_write high to reg 5 during busy. Required: reg5 unchanged, ext_write_dropped pulses once. Concurrent ext_read of a register under modification returns old then new value per 1-cycle latency.
- Start a 31-register pass with mode=3, operand=0xA5, and assert reset_n low in cycle 10. Required: outputs 0 next cycle, all registers 0, no done pulse.
- Assert start again in the done cycle. Required: second pass starts without an IDLE gap cycle, and op_count restarts at 0.
